// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake and control bundle between rv_multicycle_ctrl and its instruction memory / datapath.
// The master modport is the controller's view; slave is the environment's view.
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt;
    logic             imem_valid;
    logic [31:0]      imem_rdata;
    logic             imem_req;
    logic [31:0]      instr_opcode;
    logic [3:0]       alu_controls;
    logic             reg_wr_en;
    logic             pc_en;
    logic             busy;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  start, halt, imem_valid, imem_rdata,
        output imem_req, instr_opcode, alu_controls, reg_wr_en, pc_en,
               busy, trap, trap_cause, retired_cnt
    );

    modport slave (
        output start, halt, imem_valid, imem_rdata,
        input  imem_req, instr_opcode, alu_controls, reg_wr_en, pc_en,
               busy, trap, trap_cause, retired_cnt
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32 R-type register/ALU datapath.
// Every output is a flop loaded from the next-state decode, so outputs follow the state with no input path.
module rv_multicycle_ctrl #(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rv_multicycle_ctrl_if.master bus
);
    localparam int TO_W = $clog2(FETCH_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [4:0]       w_dec;
    logic [31:0]      r_ir;
    logic [3:0]       r_alu;
    logic [TO_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0] r_retired;
    logic             r_imem_req;
    logic             r_reg_wr_en;
    logic             r_pc_en;
    logic             r_busy;
    logic             r_trap;
    logic [1:0]       r_trap_cause;

    // Returns {legal, alu_code}; anything other than the ten listed R-type encodings is illegal.
    function automatic logic [4:0] alu_decode(input logic [31:0] ir);
        logic [4:0] res;
        res = {1'b0, 4'd0};
        if (ir[6:0] == 7'b0110011) begin
            case ({ir[31:25], ir[14:12]})
                {7'b0000000, 3'b000}: res = {1'b1, 4'd0};
                {7'b0100000, 3'b000}: res = {1'b1, 4'd1};
                {7'b0000000, 3'b001}: res = {1'b1, 4'd2};
                {7'b0000000, 3'b101}: res = {1'b1, 4'd3};
                {7'b0100000, 3'b101}: res = {1'b1, 4'd4};
                {7'b0000000, 3'b010}: res = {1'b1, 4'd5};
                {7'b0000000, 3'b011}: res = {1'b1, 4'd6};
                {7'b0000000, 3'b100}: res = {1'b1, 4'd7};
                {7'b0000000, 3'b110}: res = {1'b1, 4'd8};
                {7'b0000000, 3'b111}: res = {1'b1, 4'd9};
                default:              res = {1'b0, 4'd0};
            endcase
        end else begin
            res = {1'b0, 4'd0};
        end
        return res;
    endfunction

    // Next-state decode; a valid word in the last allowed FETCH cycle beats the timeout.
    always_comb begin
        w_next_state = r_state;
        w_dec        = alu_decode(r_ir);
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_FETCH;
                else           w_next_state = S_IDLE;
            end
            S_FETCH: begin
                if (bus.imem_valid)          w_next_state = S_DECODE;
                else if (r_to_cnt == TO_LAST) w_next_state = S_TRAP;
                else                          w_next_state = S_FETCH;
            end
            S_DECODE: begin
                if (w_dec[4]) w_next_state = S_EXECUTE;
                else          w_next_state = S_TRAP;
            end
            S_EXECUTE:   w_next_state = S_WRITEBACK;
            S_WRITEBACK: begin
                if (bus.halt) w_next_state = S_IDLE;
                else          w_next_state = S_FETCH;
            end
            S_TRAP:      w_next_state = S_TRAP;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // State, IR, ALU code, timeout and retire counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ir      <= 32'd0;
            r_alu     <= 4'd0;
            r_to_cnt  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH && bus.imem_valid) r_ir <= bus.imem_rdata;
            if (r_state == S_DECODE && w_dec[4]) r_alu <= w_dec[3:0];
            if (r_state != S_FETCH) r_to_cnt <= '0;
            else if (!bus.imem_valid) r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_state == S_WRITEBACK) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Output flops loaded from the state being entered; trap cause latched once on trap entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req   <= 1'b0;
            r_reg_wr_en  <= 1'b0;
            r_pc_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'd0;
        end else begin
            r_imem_req  <= (w_next_state == S_FETCH);
            r_pc_en     <= (w_next_state == S_WRITEBACK);
            r_reg_wr_en <= (w_next_state == S_WRITEBACK) && (r_ir[11:7] != 5'd0);
            r_busy      <= (w_next_state == S_FETCH) || (w_next_state == S_DECODE) ||
                           (w_next_state == S_EXECUTE) || (w_next_state == S_WRITEBACK);
            r_trap      <= (w_next_state == S_TRAP);
            if (r_state != S_TRAP && w_next_state == S_TRAP)
                r_trap_cause <= (r_state == S_DECODE) ? 2'd1 : 2'd2;
        end
    end

    assign bus.imem_req     = r_imem_req;
    assign bus.instr_opcode = r_ir;
    assign bus.alu_controls = r_alu;
    assign bus.reg_wr_en    = r_reg_wr_en;
    assign bus.pc_en        = r_pc_en;
    assign bus.busy         = r_busy;
    assign bus.trap         = r_trap;
    assign bus.trap_cause   = r_trap_cause;
    assign bus.retired_cnt  = r_retired;
endmodule
